// File: rtl/dispatch_vrp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dispatch_vrp: 1-to-WIDTH valid/ready dispatcher, 2-entry buffer per port. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dispatch_vrp #(
  parameter int MODE       = 0,
  parameter int WIDTH      = 4,
  parameter int PLD_WIDTH  = 32,
  parameter int DEST_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              vld_s,
  output logic                              rdy_s,
  input  logic [PLD_WIDTH-1:0]              pld_s,
  input  logic [DEST_WIDTH-1:0]             dest_s,
  output logic [WIDTH-1:0]                  v_vld_m,
  input  logic [WIDTH-1:0]                  v_rdy_m,
  output logic [WIDTH-1:0][PLD_WIDTH-1:0]   v_pld_m,
  output logic                              drop_o,
  output logic [DEST_WIDTH-1:0]             rr_ptr_o
);

  localparam bit RR = (MODE == 1);

  logic [WIDTH-1:0]      full;
  logic [WIDTH-1:0]      push;
  logic [WIDTH-1:0]      pop;
  logic [DEST_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [DEST_WIDTH-1:0] rr_tgt;
  logic [DEST_WIDTH-1:0] sel;
  logic                  rr_found;
  logic                  dest_ok;
  logic                  tgt_ok;
  logic                  accept;
  logic                  drop_q, drop_d;

  // Readiness looks only at registered fill levels, never at v_rdy_m.
  always_comb begin
    dest_ok  = 32'(dest_s) < 32'(WIDTH);
    rr_found = 1'b0;
    rr_tgt   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!rr_found && !full[DEST_WIDTH'((int'(rr_ptr_q) + k) % WIDTH)]) begin
        rr_found = 1'b1;
        rr_tgt   = DEST_WIDTH'((int'(rr_ptr_q) + k) % WIDTH);
      end
    end

    if (RR) begin
      sel    = rr_tgt;
      tgt_ok = rr_found;
      rdy_s  = ~rst & rr_found;
    end else begin
      sel    = dest_s;
      tgt_ok = dest_ok;
      rdy_s  = ~rst & (~dest_ok | ~full[dest_s]);
    end

    accept   = vld_s & rdy_s;
    drop_d   = accept & ~RR & ~dest_ok;
    rr_ptr_d = rr_ptr_q;
    if (RR && accept) begin
      rr_ptr_d = (32'(rr_tgt) == 32'(WIDTH - 1)) ? '0 : rr_tgt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      drop_q   <= drop_d;
    end
  end

  assign drop_o   = drop_q;
  assign rr_ptr_o = rr_ptr_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_port
    logic [1:0]           cnt_q, cnt_d;
    logic [PLD_WIDTH-1:0] head_q, head_d;
    logic [PLD_WIDTH-1:0] tail_q, tail_d;

    assign full[i]    = (cnt_q == 2'd2);
    assign pop[i]     = (cnt_q != 2'd0) & v_rdy_m[i];
    assign push[i]    = accept & tgt_ok & (sel == DEST_WIDTH'(i));
    assign v_vld_m[i] = (cnt_q != 2'd0);
    assign v_pld_m[i] = head_q;

    // Head is entry 0; a pop shifts the tail forward before any write lands.
    always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q + {1'b0, push[i]} - {1'b0, pop[i]};
      if (pop[i]) begin
        head_d = tail_q;
      end
      if (push[i]) begin
        if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop[i])) begin
          head_d = pld_s;
        end else begin
          tail_d = pld_s;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= 2'd0;
        head_q <= '0;
        tail_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        head_q <= head_d;
        tail_q <= tail_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dispatch_vrp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dispatch_vrp: queue-model bench over three dispatch_vrp configs.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dispatch_vrp;

  // Instance 0: MODE 0 / WIDTH 4, instance 1: MODE 0 / WIDTH 3, instance 2: MODE 1 / WIDTH 4.
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  vld = '0;
  logic [1:0]  dest [3];
  logic [31:0] pld  [3];
  logic [3:0]  vrdy [3];

  logic [2:0]  rdy;
  logic [2:0]  drop;
  logic [1:0]  rrp  [3];
  logic [3:0]  vvld [3];
  logic [3:0][31:0] vpld [3];

  logic [3:0]       vvld_a, vvld_c;
  logic [2:0]       vvld_b;
  logic [3:0][31:0] vpld_a, vpld_c;
  logic [2:0][31:0] vpld_b;

  assign vvld[0] = vvld_a;
  assign vvld[1] = {1'b0, vvld_b};
  assign vvld[2] = vvld_c;
  assign vpld[0] = vpld_a;
  assign vpld[1] = {32'h0, vpld_b};
  assign vpld[2] = vpld_c;

  always #5 clk = ~clk;

  dispatch_vrp #(.MODE(0), .WIDTH(4), .PLD_WIDTH(32)) u_a (
    .clk(clk), .rst(rst), .vld_s(vld[0]), .rdy_s(rdy[0]), .pld_s(pld[0]), .dest_s(dest[0]),
    .v_vld_m(vvld_a), .v_rdy_m(vrdy[0]), .v_pld_m(vpld_a), .drop_o(drop[0]), .rr_ptr_o(rrp[0])
  );
  dispatch_vrp #(.MODE(0), .WIDTH(3), .PLD_WIDTH(32)) u_b (
    .clk(clk), .rst(rst), .vld_s(vld[1]), .rdy_s(rdy[1]), .pld_s(pld[1]), .dest_s(dest[1]),
    .v_vld_m(vvld_b), .v_rdy_m(vrdy[1][2:0]), .v_pld_m(vpld_b), .drop_o(drop[1]), .rr_ptr_o(rrp[1])
  );
  dispatch_vrp #(.MODE(1), .WIDTH(4), .PLD_WIDTH(32)) u_c (
    .clk(clk), .rst(rst), .vld_s(vld[2]), .rdy_s(rdy[2]), .pld_s(pld[2]), .dest_s(dest[2]),
    .v_vld_m(vvld_c), .v_rdy_m(vrdy[2]), .v_pld_m(vpld_c), .drop_o(drop[2]), .rr_ptr_o(rrp[2])
  );

  // Reference model: one FIFO per port, each holding at most two beats.
  logic [31:0] q [3][4][$];
  int          W [3] = '{4, 3, 4};
  int          rr_m = 0;
  bit          edrop [3];
  bit          last_acc [3];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero();
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < W[n]; i++) begin
        chk($sformatf("rst_vld%0d_%0d", n, i), {31'h0, vvld[n][i]}, 32'h0);
        chk($sformatf("rst_pld%0d_%0d", n, i), vpld[n][i], 32'h0);
      end
      chk($sformatf("rst_rr%0d", n), {30'h0, rrp[n]}, 32'h0);
    end
  endtask

  // Compare outputs against the model, then advance both across one clock edge.
  task automatic cycle();
    bit acc [3];
    int tgt [3];
    bit popm [3][4];
    #1;
    for (int n = 0; n < 3; n++) begin
      bit er;
      int t;
      er = 1'b0;
      t  = -1;
      if (n == 2) begin
        for (int k = 0; k < 4; k++)
          if (t < 0 && q[2][(rr_m + k) % 4].size() < 2) t = (rr_m + k) % 4;
        er = (t >= 0);
      end else if (int'(dest[n]) < W[n]) begin
        t  = int'(dest[n]);
        er = (q[n][t].size() < 2);
      end else begin
        er = 1'b1;
      end
      if (rst) er = 1'b0;
      chk($sformatf("rdy%0d", n), {31'h0, rdy[n]}, {31'h0, er});
      chk($sformatf("drop%0d", n), {31'h0, drop[n]}, {31'h0, edrop[n]});
      chk($sformatf("rr%0d", n), {30'h0, rrp[n]}, (n == 2) ? 32'(rr_m) : 32'h0);
      for (int i = 0; i < W[n]; i++) begin
        chk($sformatf("vld%0d_%0d", n, i), {31'h0, vvld[n][i]}, {31'h0, q[n][i].size() != 0});
        if (q[n][i].size() != 0) chk($sformatf("pld%0d_%0d", n, i), vpld[n][i], q[n][i][0]);
        popm[n][i] = (q[n][i].size() != 0) && vrdy[n][i];
      end
      acc[n] = vld[n] & er;
      tgt[n] = t;
    end
    @(posedge clk);
    for (int n = 0; n < 3; n++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) q[n][i].delete();
        edrop[n] = 1'b0;
      end else begin
        for (int i = 0; i < W[n]; i++) if (popm[n][i]) void'(q[n][i].pop_front());
        edrop[n] = acc[n] && tgt[n] < 0;
        if (acc[n] && tgt[n] >= 0) q[n][tgt[n]].push_back(pld[n]);
        if (n == 2 && acc[n]) rr_m = (tgt[n] + 1) % 4;
      end
      last_acc[n] = acc[n];
    end
    if (rst) rr_m = 0;
    #1;
  endtask

  task automatic send(int n, logic [1:0] d, logic [31:0] p);
    vld[n]  = 1'b1;
    dest[n] = d;
    pld[n]  = p;
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (last_acc[n]) break;
    end
    chk($sformatf("accept%0d", n), {31'h0, last_acc[n]}, 32'h1);
    vld[n] = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < 3; n++) begin
      dest[n] = '0; pld[n] = '0; vrdy[n] = 4'hF; edrop[n] = 1'b0; last_acc[n] = 1'b0;
    end

    // Reset state.
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    chk_zero();

    // MODE 0: one beat per port, back to back.
    for (int k = 0; k < 4; k++) send(0, 2'(k), 32'hA0 + 32'(k));
    repeat (2) cycle();

    // MODE 0: port 2 stalls, port 1 keeps flowing.
    vrdy[0] = 4'b1011;
    send(0, 2, 32'h1);
    send(0, 2, 32'h2);
    vld[0] = 1'b1; dest[0] = 2; pld[0] = 32'h3;
    cycle();
    cycle();
    chk("stall_dest2", {31'h0, last_acc[0]}, 32'h0);
    vld[0] = 1'b0;
    send(0, 1, 32'h55);
    chk("bypass_dest1", {31'h0, last_acc[0]}, 32'h1);
    vrdy[0] = 4'hF;
    send(0, 2, 32'h3);
    repeat (4) cycle();

    // MODE 0 / WIDTH 3: out-of-range destinations are dropped.
    send(1, 3, 32'hDEAD);
    cycle();
    send(1, 3, 32'hBEEF);
    send(1, 3, 32'hCAFE);
    send(1, 0, 32'h10);
    send(1, 2, 32'h12);
    repeat (3) cycle();

    // MODE 1: rotation over all ports.
    for (int k = 0; k < 8; k++) send(2, 2'($urandom), 32'h100 + 32'(k));
    chk("rr_wrap", {30'h0, rrp[2]}, 32'h0);
    repeat (3) cycle();

    // MODE 1: port 1 held, then everything held until all ports are full.
    vrdy[2] = 4'b1101;
    for (int k = 0; k < 8; k++) send(2, 2'($urandom), 32'h200 + 32'(k));
    vrdy[2] = 4'h0;
    vld[2]  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      pld[2] = $urandom;
      cycle();
    end
    chk("all_full", {31'h0, rdy[2]}, 32'h0);
    vld[2] = 1'b0;

    // Reset with beats buffered on several ports.
    vrdy[0] = 4'h0;
    send(0, 0, 32'h301); send(0, 0, 32'h302);
    send(0, 3, 32'h303); send(0, 3, 32'h304);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk_zero();
    vrdy[0] = 4'hF;
    vrdy[2] = 4'hF;
    send(2, 2'd3, 32'h77);
    cycle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int n = 0; n < 3; n++) begin
        vld[n]  = 1'($urandom);
        dest[n] = 2'($urandom);
        pld[n]  = $urandom;
        vrdy[n] = 4'($urandom);
      end
      cycle();
    end
    rst = 1'b0;
    vld = '0;
    for (int n = 0; n < 3; n++) vrdy[n] = 4'hF;
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dispatch_vrp.md
Name: dispatch_vrp

Overview:
- 1-to-N valid/ready dispatcher: the fan-out counterpart of the N-to-1 arbiter. It takes one upstream stream and delivers each beat to exactly one of WIDTH downstream ports.
- Each beat is routed either by an explicit destination field (MODE 0) or by round-robin load balancing across non-full ports (MODE 1).
- Every output port has a 2-entry buffer. Outputs are registered, and a port that stalls does not block beats bound for other ports.

Parameters:
- MODE, 0, 0: destination-routed; 1: round-robin to any non-full port; other values behave as 0.
- WIDTH, 4, number of output ports (2..16).
- PLD_WIDTH, 32, payload width in bits.
- DEST_WIDTH, $clog2(WIDTH), width of dest_s (minimum 1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- vld_s  input  1  upstream valid.
- rdy_s  output  1  upstream ready.
- pld_s  input  PLD_WIDTH  upstream payload.
- dest_s  input  DEST_WIDTH  destination port index; used in MODE 0, ignored in MODE 1.
- v_vld_m  output  WIDTH  per-port valid, driven by registers.
- v_rdy_m  input  WIDTH  per-port ready.
- v_pld_m  output  PLD_WIDTH x [WIDTH-1:0]  per-port payload, head of that port's buffer.
- drop_o  output  1  one-cycle pulse when a beat with an out-of-range dest_s is accepted and discarded.
- rr_ptr_o  output  DEST_WIDTH  current round-robin pointer (debug; constant 0 in MODE 0).

Behaviour:
- Reset (rst=1 at a clk edge):
  - All buffer counts go to 0; v_vld_m=0.
  - Buffer payload storage clears to 0, so v_pld_m=0.
  - rr_ptr_o=0; drop_o=0.
  - Reset mid-operation discards all buffered beats with no partial delivery.
  - rdy_s is 0 while rst=1.
- Per-port buffer (2 entries, FIFO order):
  - cnt[i] ranges 0..2; full[i] = (cnt[i]==2).
  - v_vld_m[i] = (cnt[i]!=0); v_pld_m[i] = head entry.
  - Pop: v_vld_m[i] & v_rdy_m[i] at the edge.
  - Push: an accepted upstream beat targeting port i.
  - Push and pop in the same cycle: cnt unchanged. The head advances and the new beat enters at the tail, so 2-entry throughput is one beat/cycle/port.
  - Per-port ordering is strictly preserved.
- Upstream handshake:
  - Accept = vld_s & rdy_s at the clk edge.
  - rdy_s never depends combinationally on v_rdy_m; it depends only on registered cnt and on dest_s.
- MODE 0:
  - If dest_s < WIDTH: rdy_s = ~full[dest_s]. The beat is pushed to port dest_s.
  - If dest_s >= WIDTH (possible only when WIDTH is not a power of 2): rdy_s=1 and the beat is dropped. drop_o=1 in the cycle after the accept edge, for exactly one cycle per dropped beat; back-to-back drops hold drop_o high on consecutive cycles.
- MODE 1:
  - Target = first port i with ~full[i], searched cyclically starting at rr_ptr_o and wrapping WIDTH-1 -> 0.
  - rdy_s = |(~full).
  - On accept, rr_ptr_o <= (target==WIDTH-1) ? 0 : target+1.
  - With no accept, rr_ptr_o holds.
  - dest_s is ignored; drop_o stays 0.
- Latency:
  - An accepted beat appears on v_vld_m/v_pld_m of its port at the next cycle if that port's buffer was empty.
  - Otherwise it appears after the earlier beats on that port drain.
  - There is no combinational path from vld_s/pld_s to any output port.
- Boundary cases:
  - Port full and its ready low: MODE 0 beats for that port stall upstream. MODE 1 skips that port.
  - Port full with v_rdy_m[i]=1 in the same cycle: upstream is still not ready for that port this cycle (conservative by design). Verification must not expect acceptance.
  - All ports full: rdy_s=0 in both modes.
  - vld_s=0: no state change except pops.
  - v_vld_m[i] is never deasserted, and v_pld_m[i] never changes, while v_vld_m[i]=1 & v_rdy_m[i]=0.

Test Plan:
- MODE 0, WIDTH 4, all v_rdy_m=1: send pld 0xA0..0xA3 with dest 0,1,2,3 on consecutive cycles -> each appears one cycle after accept on its port. rdy_s stays 1; zero bubbles.
- MODE 0, v_rdy_m[2]=0: send 3 beats to dest 2 -> first two accepted. Third sees rdy_s=0 until v_rdy_m[2] rises, after which port 2 delivers 0x1,0x2,0x3 in order. A beat to dest 1 issued during the stall (after the dest-2 beat is withdrawn) is accepted immediately.
- MODE 0, WIDTH 3: send dest_s=3 with pld 0xDEAD -> rdy_s=1, drop_o pulses once the next cycle, and no v_vld_m asserts.
- MODE 1, WIDTH 4, all ready: 8 back-to-back beats -> ports receive them in order 0,1,2,3,0,1,2,3; rr_ptr_o ends at 0.
- MODE 1: hold v_rdy_m[1]=0 and fill port 1 (cnt=2) -> subsequent beats skip port 1 in rotation. After 8 more beats all v_rdy_m=0 and every port is full, so rdy_s=0.
- Reset mid-stream: with ports 0 and 3 holding 2 beats each, assert rst for 1 cycle -> next cycle all v_vld_m=0, v_pld_m=0, rr_ptr_o=0. The first beat after reset goes to port 0 (MODE 1).
